// File: rtl/dbus_bridge.sv
// Data-memory bridge: posts core writes into an in-order buffer and turns each core
// access into a registered req/ack bus transfer, with a watchdog and sticky error flag.
module dbus_bridge #(
    parameter int WB_DEPTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_ce_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_sel_i,
    output logic [31:0] core_rdata_o,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR      = 2'd1;
    localparam logic [1:0] S_RD      = 2'd2;
    localparam logic [1:0] S_RD_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_sel_q, bus_sel_d;
    logic             bus_err_q, bus_err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [67:0]      fifo_q [WB_DEPTH];
    logic [31:0]      head_addr;
    logic [31:0]      head_wdata;
    logic [3:0]       head_sel;

    logic             xfer_done;
    logic             timeout;
    logic             pop;
    logic             push;
    logic             full;

    assign {head_addr, head_wdata, head_sel} = fifo_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        bus_err_d   = bus_err_q;
        rdata_d     = rdata_q;

        xfer_done = bus_req_q && bus_ack_i;
        timeout   = bus_req_q && !bus_ack_i && (tcnt_q == TO_LAST);
        tcnt_d    = (bus_req_q && !bus_ack_i) ? tcnt_q + TO_W'(1) : '0;

        pop  = (state_q == S_WR) && (xfer_done || timeout);
        full = (count_q == CNT_W'(WB_DEPTH));
        push = core_ce_i && core_we_i && (!full || pop);

        // A read is held off until its data is presented in RD_DONE.
        stall_o = (core_ce_i && core_we_i && full && !pop) ||
                  (core_ce_i && !core_we_i && (state_q != S_RD_DONE));

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = head_addr;
                    bus_wdata_d = head_wdata;
                    bus_sel_d   = head_sel;
                    state_d     = S_WR;
                end else if (core_ce_i && !core_we_i) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = core_addr_i;
                    bus_wdata_d = '0;
                    bus_sel_d   = core_sel_i;
                    state_d     = S_RD;
                end
            end
            S_WR: begin
                if (xfer_done || timeout) begin
                    bus_req_d = 1'b0;
                    state_d   = S_IDLE;
                    if (timeout) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (xfer_done) begin
                    rdata_d   = bus_rdata_i;
                    bus_req_d = 1'b0;
                    state_d   = S_RD_DONE;
                end else if (timeout) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = S_RD_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tcnt_q      <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            bus_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tcnt_q      <= tcnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            bus_err_q   <= bus_err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Buffer storage carries no reset; count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {core_addr_i, core_wdata_i, core_sel_i};
        end
    end

    assign core_rdata_o = (state_q == S_RD_DONE) ? rdata_q : '0;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_sel_o    = bus_sel_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: directed latency/full/timeout/reset cases plus random traffic
// checked against a program-order transaction queue and a byte-lane memory model.
module tb_dbus_bridge;

    localparam int TB_TIMEOUT = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_ce_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic [3:0]  core_sel_i;
    logic [31:0] core_rdata_o;
    logic        stall_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    logic        slave_ack, force_ack;
    assign bus_ack_i = slave_ack | force_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int req_hi   = 0;

    bit slave_go   = 1'b1;
    bit rand_delay = 1'b0;
    int ack_delay  = 0;
    int wait_n     = 0;

    txn_t        exp_q [$];
    txn_t        mon_e;
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] last_rdata;

    dbus_bridge #(.WB_DEPTH(4), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .core_ce_i(core_ce_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_sel_i(core_sel_i), .core_rdata_o(core_rdata_o),
        .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hDEAD_0000);
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : (a ^ 32'hDEAD_0000);
    endfunction

    // Bus slave: acks after ack_delay wait cycles of an active request.
    initial begin
        slave_ack = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req_o && !rst) begin
                if (wait_n == 0 && rand_delay) ack_delay = $urandom_range(0, 3);
                if (slave_go && wait_n >= ack_delay) begin
                    slave_ack = 1'b1;
                    bus_rdata_i = bus_we_o ? 32'h0 : slave_read(bus_addr_o);
                    wait_n = 0;
                end else begin
                    slave_ack = 1'b0;
                    wait_n++;
                end
            end else begin
                slave_ack = 1'b0;
                wait_n = 0;
            end
        end
    end

    // Completed bus transfers must match core operations in program order.
    always @(negedge clk) begin
        if (bus_req_o) req_hi++;
        if (!rst && bus_req_o && bus_ack_i) begin
            if (exp_q.size() == 0) begin
                chk("bus_unexpected_xfer", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bus_we", {31'd0, bus_we_o}, {31'd0, mon_e.we});
                chk("bus_addr", bus_addr_o, mon_e.addr);
                chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, mon_e.sel});
                if (mon_e.we) begin
                    chk("bus_wdata", bus_wdata_o, mon_e.data);
                    slave_mem[bus_addr_o] = merge(slave_read(bus_addr_o), bus_wdata_o, bus_sel_o);
                end
                n_done++;
            end
        end
    end

    // Presents one core access (called at posedge+1) and holds it until stall_o drops.
    task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] sel, input bit to, output int stalls);
        logic [31:0] exp_rd;
        bit done = 1'b0;
        core_ce_i = 1'b1; core_we_i = we; core_addr_i = addr;
        core_wdata_i = wd; core_sel_i = sel;
        exp_rd = to ? 32'h0 : ref_read(addr);
        if (!we && !to) exp_q.push_back('{we: 1'b0, addr: addr, data: 32'h0, sel: sel});
        stalls = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (!stall_o) begin
                done = 1'b1;
                if (we) begin
                    ref_mem[addr] = merge(ref_read(addr), wd, sel);
                    exp_q.push_back('{we: 1'b1, addr: addr, data: wd, sel: sel});
                end else begin
                    last_rdata = core_rdata_o;
                    chk("core_rdata", core_rdata_o, exp_rd);
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        chk("op_completed", {31'd0, done}, 32'd1);
    endtask

    task automatic idle(input int n);
        core_ce_i = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus_req_o) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   {31'd0, bus_req_o}, 32'd0);
        chk({tag, "_we"},    {31'd0, bus_we_o},  32'd0);
        chk({tag, "_addr"},  bus_addr_o, 32'd0);
        chk({tag, "_wdata"}, bus_wdata_o, 32'd0);
        chk({tag, "_sel"},   {28'd0, bus_sel_o}, 32'd0);
        chk({tag, "_err"},   {31'd0, bus_err_o}, 32'd0);
        chk({tag, "_rdata"}, core_rdata_o, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_o},   32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int st;
        int sts [5];
        int base;
        rst = 1'b1; force_ack = 1'b0;
        core_ce_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0; core_sel_i = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Posted write, ack after one wait cycle.
        ack_delay = 1;
        base = n_done;
        do_op(1'b1, 32'h1000, 32'hA5A5_A5A5, 4'hF, 1'b0, st);
        chk("posted_write_stall", 32'(st), 32'd0);
        idle(0);
        drain();
        chk("posted_write_count", 32'(n_done - base), 32'd1);

        // Buffer full: ack withheld for six cycles.
        slave_go = 1'b0; ack_delay = 0;
        base = n_done;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    do_op(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0, sts[i]);
                core_ce_i = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                slave_go = 1'b1;
            end
        join
        for (int i = 0; i < 4; i++) chk("full_early_stall", 32'(sts[i]), 32'd0);
        chk("full_fifth_stall", 32'(sts[4]), 32'd2);
        drain();
        chk("full_write_count", 32'(n_done - base), 32'd5);
        chk("full_no_err", {31'd0, bus_err_o}, 32'd0);

        // Read-after-write with immediate ack.
        ack_delay = 0;
        do_op(1'b1, 32'h20, 32'h11, 4'hF, 1'b0, st);
        do_op(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, st);
        chk("raw_stall", 32'(st), 32'd4);
        chk("raw_data", last_rdata, 32'h11);
        idle(1);
        drain();

        // Read latency on an empty buffer.
        do_op(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, st);
        chk("rd_delay0_stall", 32'(st), 32'd2);
        ack_delay = 3;
        do_op(1'b0, 32'h44, 32'h0, 4'h6, 1'b0, st);
        chk("rd_delay3_stall", 32'(st), 32'd5);
        core_ce_i = 1'b0;
        @(negedge clk);
        chk("rd_data_after_done", core_rdata_o, 32'd0);
        @(posedge clk); #1;

        // Random traffic.
        rand_delay = 1'b1;
        for (int i = 0; i < 200; i++) begin
            do_op(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(1, 15)), 1'b0, st);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(0);
        drain();
        chk("random_no_err", {31'd0, bus_err_o}, 32'd0);
        rand_delay = 1'b0;

        // Read timeout.
        slave_go = 1'b0;
        req_hi = 0;
        do_op(1'b0, 32'h80, 32'h0, 4'hC, 1'b1, st);
        core_ce_i = 1'b0;
        chk("timeout_stall", 32'(st), 32'(TB_TIMEOUT + 1));
        chk("timeout_req_cycles", 32'(req_hi), 32'(TB_TIMEOUT));
        chk("timeout_err_set", {31'd0, bus_err_o}, 32'd1);
        idle(3);
        @(negedge clk);
        chk("timeout_err_sticky", {31'd0, bus_err_o}, 32'd1);
        @(posedge clk); #1;

        // Reset during a read, followed by a stray ack.
        core_ce_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h300;
        core_sel_i = 4'h3; core_wdata_i = 32'h0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_rd_req_active", {31'd0, bus_req_o}, 32'd1);
        rst = 1'b1; core_ce_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; force_ack = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        check_all_zero("rst_late_ack");
        repeat (4) begin
            @(negedge clk);
            chk("rst_fifo_empty_req", {31'd0, bus_req_o}, 32'd0);
        end
        @(posedge clk); #1;
        slave_go = 1'b1; ack_delay = 0;
        do_op(1'b0, 32'h304, 32'h0, 4'hF, 1'b0, st);
        chk("post_rst_rd_stall", 32'(st), 32'd2);
        idle(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
